// File: rtl/vfifo_bus_core.sv
// vfifo_bus_core
// Show-ahead FIFO between a data producer and a streaming consumer, with an
// 8-bit register bus for control and status: byte-size reporting with a
// 32-bit snapshot, an almost-full/almost-empty hysteresis flag, and
// saturating read-error and overflow counters. A write to register 0 acts
// as a soft reset. Single clock domain with a synchronous active-high reset.
module vfifo_bus_core #(
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH            = 8192,
  parameter int ALMOST_FULL_PCT  = 95,
  parameter int ALMOST_EMPTY_PCT = 5,
  parameter int ABUSWIDTH        = 16
) (
  input  logic                  BUS_CLK,
  input  logic                  RST,
  input  logic [ABUSWIDTH-1:0]  BUS_ADD,
  input  logic [7:0]            BUS_DATA_IN,
  input  logic                  BUS_RD,
  input  logic                  BUS_WR,
  output logic [7:0]            BUS_DATA_OUT,
  input  logic                  FIFO_WRITE,
  input  logic [DATA_WIDTH-1:0] FIFO_DATA_IN,
  output logic                  FIFO_FULL,
  input  logic                  FIFO_READ,
  output logic [DATA_WIDTH-1:0] FIFO_DATA_OUT,
  output logic                  FIFO_EMPTY,
  output logic                  FIFO_NEAR_FULL,
  output logic                  FIFO_READ_ERROR
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;  // pointer width including the wrap bit
  localparam int TW = AW + 9;  // (reg+1)*DEPTH needs 9 extra bits
  localparam logic [7:0]    VERSION = 8'd2;
  localparam logic [7:0]    AF_RST  = 8'(255 * ALMOST_FULL_PCT / 100);
  localparam logic [7:0]    AE_RST  = 8'(255 * ALMOST_EMPTY_PCT / 100);
  localparam logic [7:0]    BYTES   = 8'(DATA_WIDTH / 8);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_vis_q, wr_vis_d;   // write pointer as seen by the read side
  logic [7:0]    af_q, af_d;
  logic [7:0]    ae_q, ae_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;
  logic [7:0]    bus_data_q, bus_data_d;
  logic [31:0]   snap_q, snap_d;
  logic          near_full_q, near_full_d;

  logic          soft_rst, full, empty, push_ok, pop_ok;
  logic [PW-1:0] size;
  logic [31:0]   size_byte;
  logic [TW-1:0] af_thr, ae_thr;
  logic [7:0]    rd_mux;

  // Occupancy, flags, accept strobes and hysteresis thresholds.
  // NOTE: combinational blocks use blocking '=' so later lines see earlier
  // results; clocked blocks use '<=' so every flop samples pre-edge values.
  always_comb begin
    soft_rst  = RST | (BUS_WR & (BUS_ADD == '0));
    size      = wr_ptr_q - rd_ptr_q;
    full      = (size == DEPTH_P);
    // Empty follows the delayed write pointer so a new word is only shown
    // once the registered RAM read has picked it up.
    empty     = (wr_vis_q == rd_ptr_q);
    push_ok   = FIFO_WRITE & ~full;
    pop_ok    = FIFO_READ & ~empty;
    size_byte = 32'(size) * 32'(BYTES);
    af_thr    = ((TW'(af_q) + TW'(1)) * TW'(DEPTH)) >> 8;
    ae_thr    = ((TW'(ae_q) + TW'(1)) * TW'(DEPTH)) >> 8;
  end

  // Register-map read multiplexer.
  always_comb begin
    rd_mux = 8'h00;
    case (BUS_ADD)
      ABUSWIDTH'(0):  rd_mux = VERSION;
      ABUSWIDTH'(1):  rd_mux = af_q;
      ABUSWIDTH'(2):  rd_mux = ae_q;
      ABUSWIDTH'(3):  rd_mux = {4'b0000, (err_cnt_q != 8'd0), near_full_q, full, empty};
      ABUSWIDTH'(4):  rd_mux = size_byte[7:0];
      ABUSWIDTH'(5):  rd_mux = snap_q[15:8];
      ABUSWIDTH'(6):  rd_mux = snap_q[23:16];
      ABUSWIDTH'(7):  rd_mux = snap_q[31:24];
      ABUSWIDTH'(8):  rd_mux = err_cnt_q;
      ABUSWIDTH'(9):  rd_mux = ovf_cnt_q;
      ABUSWIDTH'(10): rd_mux = BYTES;
      default:        rd_mux = 8'h00;
    endcase
  end

  // Next-state logic for pointers, counters, flag and bus registers.
  // NOTE: every _d gets its hold value first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_vis_d    = wr_ptr_q;
    af_d        = af_q;
    ae_d        = ae_q;
    err_cnt_d   = err_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    bus_data_d  = bus_data_q;
    snap_d      = snap_q;
    near_full_d = near_full_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);

    // Fullness is judged before any same-cycle pop, so such a push is lost.
    if (FIFO_WRITE && full && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
    if (FIFO_READ && empty && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

    // Hysteresis: set wins over clear; in between the flag holds.
    if ((TW'(size) >= af_thr) || (af_q == 8'd0)) begin
      near_full_d = 1'b1;
    end else if (((ae_q != 8'd0) && (TW'(size) <= ae_thr)) || (size == '0)) begin
      near_full_d = 1'b0;
    end

    if (BUS_WR && (BUS_ADD == ABUSWIDTH'(1))) af_d = BUS_DATA_IN;
    if (BUS_WR && (BUS_ADD == ABUSWIDTH'(2))) ae_d = BUS_DATA_IN;

    if (BUS_RD) begin
      bus_data_d = rd_mux;
      if (BUS_ADD == ABUSWIDTH'(4)) snap_d = size_byte;
    end

    if (soft_rst) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      wr_vis_d    = '0;
      af_d        = AF_RST;
      ae_d        = AE_RST;
      err_cnt_d   = 8'd0;
      ovf_cnt_d   = 8'd0;
      bus_data_d  = 8'd0;
      snap_d      = 32'd0;
      near_full_d = 1'b0;
    end
  end

  // Control state registers; reset is already folded into the _d values.
  always_ff @(posedge BUS_CLK) begin
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    wr_vis_q    <= wr_vis_d;
    af_q        <= af_d;
    ae_q        <= ae_d;
    err_cnt_q   <= err_cnt_d;
    ovf_cnt_q   <= ovf_cnt_d;
    bus_data_q  <= bus_data_d;
    snap_q      <= snap_d;
    near_full_q <= near_full_d;
  end

  // Dual-port storage: write port plus a registered read of the next head.
  // NOTE: the array and its read register carry no reset; the pointers
  // alone decide which words are valid, which keeps this a plain block RAM.
  always_ff @(posedge BUS_CLK) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= FIFO_DATA_IN;
    rd_data_q <= mem[rd_ptr_d[AW-1:0]];
  end

  assign BUS_DATA_OUT    = bus_data_q;
  assign FIFO_DATA_OUT   = rd_data_q;
  assign FIFO_FULL       = full;
  assign FIFO_EMPTY      = empty;
  assign FIFO_NEAR_FULL  = near_full_q;
  assign FIFO_READ_ERROR = (err_cnt_q != 8'd0);

endmodule

// File: tb/tb_vfifo_bus_core.sv
// tb_vfifo_bus_core
// Directed scenarios with literal expectations, followed by a randomized
// phase. A queue-based reference model tracks the FIFO and registers and
// is compared with every DUT output once per cycle.
module tb_vfifo_bus_core;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AB    = 16;
  localparam int NB    = DW / 8;

  logic          BUS_CLK = 1'b0;
  logic          RST;
  logic [AB-1:0] BUS_ADD;
  logic [7:0]    BUS_DATA_IN;
  logic          BUS_RD, BUS_WR;
  logic [7:0]    BUS_DATA_OUT;
  logic          FIFO_WRITE, FIFO_READ;
  logic [DW-1:0] FIFO_DATA_IN, FIFO_DATA_OUT;
  logic          FIFO_FULL, FIFO_EMPTY, FIFO_NEAR_FULL, FIFO_READ_ERROR;

  always #5 BUS_CLK = ~BUS_CLK;

  vfifo_bus_core #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_PCT(95),
    .ALMOST_EMPTY_PCT(5), .ABUSWIDTH(AB)
  ) dut (
    .BUS_CLK(BUS_CLK), .RST(RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_RD(BUS_RD), .BUS_WR(BUS_WR), .BUS_DATA_OUT(BUS_DATA_OUT),
    .FIFO_WRITE(FIFO_WRITE), .FIFO_DATA_IN(FIFO_DATA_IN), .FIFO_FULL(FIFO_FULL),
    .FIFO_READ(FIFO_READ), .FIFO_DATA_OUT(FIFO_DATA_OUT), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_NEAR_FULL(FIFO_NEAR_FULL), .FIFO_READ_ERROR(FIFO_READ_ERROR)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_q[$];       // stored words, head at index 0
  bit            m_last_push;  // word accepted on the latest edge, not yet shown
  logic [7:0]    m_af, m_ae, m_err, m_ovf, m_bus;
  logic [31:0]   m_snap;
  bit            m_nf;
  bit            m_valid = 1'b0;

  always @(posedge BUS_CLK) begin
    int sz, vis, af_thr, ae_thr;
    logic [31:0] sb;
    bit full, empty, pushed;
    sz    = m_q.size();
    vis   = sz - int'(m_last_push);
    full  = (sz == DEPTH);
    empty = (vis == 0);
    sb    = 32'(sz * NB);
    if (RST || (BUS_WR && BUS_ADD == '0)) begin
      m_q.delete();
      m_last_push = 1'b0;
      m_af = 8'd242; m_ae = 8'd12; m_err = 8'd0; m_ovf = 8'd0;
      m_bus = 8'd0; m_snap = 32'd0; m_nf = 1'b0; m_valid = 1'b1;
    end else begin
      if (BUS_RD) begin
        case (BUS_ADD)
          16'd0:   m_bus = 8'd2;
          16'd1:   m_bus = m_af;
          16'd2:   m_bus = m_ae;
          16'd3:   m_bus = {4'b0000, (m_err != 8'd0), m_nf, full, empty};
          16'd4:   begin m_bus = sb[7:0]; m_snap = sb; end
          16'd5:   m_bus = m_snap[15:8];
          16'd6:   m_bus = m_snap[23:16];
          16'd7:   m_bus = m_snap[31:24];
          16'd8:   m_bus = m_err;
          16'd9:   m_bus = m_ovf;
          16'd10:  m_bus = 8'(NB);
          default: m_bus = 8'd0;
        endcase
      end
      af_thr = ((int'(m_af) + 1) * DEPTH) >> 8;
      ae_thr = ((int'(m_ae) + 1) * DEPTH) >> 8;
      if (sz >= af_thr || m_af == 8'd0) m_nf = 1'b1;
      else if ((m_ae != 8'd0 && sz <= ae_thr) || sz == 0) m_nf = 1'b0;
      if (BUS_WR && BUS_ADD == 16'd1) m_af = BUS_DATA_IN;
      if (BUS_WR && BUS_ADD == 16'd2) m_ae = BUS_DATA_IN;
      pushed = 1'b0;
      if (FIFO_WRITE) begin
        if (full) begin
          if (m_ovf != 8'hFF) m_ovf++;
        end else begin
          m_q.push_back(FIFO_DATA_IN);
          pushed = 1'b1;
        end
      end
      if (FIFO_READ) begin
        if (empty) begin
          if (m_err != 8'hFF) m_err++;
        end else begin
          void'(m_q.pop_front());
        end
      end
      m_last_push = pushed;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(posedge BUS_CLK) begin
    int vis;
    #1;
    if (m_valid) begin
      vis = m_q.size() - int'(m_last_push);
      check("empty",      FIFO_EMPTY,      (vis == 0));
      check("full",       FIFO_FULL,       (m_q.size() == DEPTH));
      check("near_full",  FIFO_NEAR_FULL,  m_nf);
      check("read_error", FIFO_READ_ERROR, (m_err != 8'd0));
      check("bus_data",   BUS_DATA_OUT,    m_bus);
      if (vis > 0) check("data_out", FIFO_DATA_OUT, m_q[0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_read(input int addr, input logic [7:0] exp, input string name);
    BUS_ADD = AB'(addr);
    BUS_RD  = 1'b1;
    @(negedge BUS_CLK);
    BUS_RD  = 1'b0;
    check(name, BUS_DATA_OUT, exp);
  endtask

  task automatic bus_write(input int addr, input logic [7:0] data);
    BUS_ADD     = AB'(addr);
    BUS_DATA_IN = data;
    BUS_WR      = 1'b1;
    @(negedge BUS_CLK);
    BUS_WR      = 1'b0;
  endtask

  task automatic push_n(input int n);
    FIFO_WRITE = 1'b1;
    for (int i = 0; i < n; i++) begin
      FIFO_DATA_IN = $urandom();
      @(negedge BUS_CLK);
    end
    FIFO_WRITE = 1'b0;
  endtask

  task automatic pop_n(input int n);
    FIFO_READ = 1'b1;
    repeat (n) @(negedge BUS_CLK);
    FIFO_READ = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge BUS_CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; BUS_ADD = '0; BUS_DATA_IN = '0; BUS_RD = 1'b0; BUS_WR = 1'b0;
    FIFO_WRITE = 1'b0; FIFO_READ = 1'b0; FIFO_DATA_IN = '0;
    repeat (2) @(negedge BUS_CLK);
    RST = 1'b0;

    // Reset state and constant registers.
    check("rst_bus_out",  BUS_DATA_OUT, 8'd0);
    check("rst_empty",    FIFO_EMPTY, 1'b1);
    check("rst_full",     FIFO_FULL, 1'b0);
    bus_read(0,  8'd2,   "reg0_version");
    bus_read(1,  8'd242, "reg1_af_default");
    bus_read(2,  8'd12,  "reg2_ae_default");
    bus_read(10, 8'd4,   "reg10_bytes");
    bus_read(3,  8'h01,  "reg3_status_rst");

    // Five words, size in bytes, in-order pop.
    FIFO_WRITE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      FIFO_DATA_IN = 32'hA0 + 32'(i);
      @(negedge BUS_CLK);
    end
    FIFO_WRITE = 1'b0;
    idle(1);
    bus_read(4, 8'd20, "reg4_size5");
    bus_read(5, 8'd0,  "reg5_size5");
    bus_read(6, 8'd0,  "reg6_size5");
    bus_read(7, 8'd0,  "reg7_size5");
    for (int i = 0; i < 5; i++) begin
      check("pop_order", FIFO_DATA_OUT, 32'hA0 + 32'(i));
      pop_n(1);
    end
    check("empty_after_pop5", FIFO_EMPTY, 1'b1);

    // Fill to DEPTH, three dropped pushes (last one with a pop), refill.
    push_n(DEPTH);
    check("full_after_fill", FIFO_FULL, 1'b1);
    FIFO_WRITE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      FIFO_DATA_IN = $urandom();
      FIFO_READ    = (i == 2);
      @(negedge BUS_CLK);
    end
    FIFO_WRITE = 1'b0; FIFO_READ = 1'b0;
    check("full_after_drop_pop", FIFO_FULL, 1'b0);
    push_n(1);
    check("full_refill", FIFO_FULL, 1'b1);
    bus_read(9, 8'd3, "reg9_ovf3");
    bus_read(4, 8'd0, "reg4_full");
    bus_read(5, 8'd4, "reg5_full");
    bus_read(6, 8'd0, "reg6_full");

    // Drain, then read errors and saturation.
    pop_n(DEPTH);
    check("empty_after_drain", FIFO_EMPTY, 1'b1);
    bus_read(8, 8'd0, "reg8_no_err");
    pop_n(2);
    bus_read(8, 8'd2, "reg8_err2");
    check("read_error_flag", FIFO_READ_ERROR, 1'b1);
    pop_n(300);
    bus_read(8, 8'd255, "reg8_sat");

    // Hysteresis with AF=191, AE=63 (set at 192, clear at 64).
    bus_write(0, 8'h55);
    bus_write(1, 8'd191);
    bus_write(2, 8'd63);
    push_n(191);
    idle(2);
    check("nf_at_191", FIFO_NEAR_FULL, 1'b0);
    push_n(1);
    idle(1);
    check("nf_at_192", FIFO_NEAR_FULL, 1'b1);
    pop_n(92);
    idle(1);
    check("nf_hold_100", FIFO_NEAR_FULL, 1'b1);
    pop_n(35);
    idle(1);
    check("nf_hold_65", FIFO_NEAR_FULL, 1'b1);
    pop_n(1);
    idle(1);
    check("nf_clear_64", FIFO_NEAR_FULL, 1'b0);

    // Soft reset in the middle of a push burst.
    pop_n(65);
    check("err_before_soft", FIFO_READ_ERROR, 1'b1);
    FIFO_WRITE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      FIFO_DATA_IN = $urandom();
      if (i == 5) begin BUS_ADD = '0; BUS_WR = 1'b1; end
      @(negedge BUS_CLK);
    end
    FIFO_WRITE = 1'b0; BUS_WR = 1'b0;
    check("soft_empty", FIFO_EMPTY, 1'b1);
    check("soft_err_flag", FIFO_READ_ERROR, 1'b0);
    bus_read(8, 8'd0,   "soft_reg8");
    bus_read(9, 8'd0,   "soft_reg9");
    bus_read(1, 8'd242, "soft_reg1");

    // Randomized traffic with fill-biased and drain-biased phases.
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = (ph % 2 == 0) ? 80 : 30;
      rp = (ph % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 500; c++) begin
        int r;
        FIFO_WRITE   = ($urandom_range(0, 99) < wp);
        FIFO_READ    = ($urandom_range(0, 99) < rp);
        FIFO_DATA_IN = $urandom();
        BUS_RD = 1'b0; BUS_WR = 1'b0;
        r = int'($urandom_range(0, 999));
        if (r < 100) begin
          BUS_RD  = 1'b1;
          BUS_ADD = AB'($urandom_range(0, 12));
        end else if (r < 130) begin
          BUS_WR      = 1'b1;
          BUS_ADD     = AB'($urandom_range(1, 3));
          BUS_DATA_IN = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom());
        end else if (r < 133) begin
          BUS_WR  = 1'b1;
          BUS_ADD = '0;
        end
        @(negedge BUS_CLK);
      end
    end
    FIFO_WRITE = 1'b0; FIFO_READ = 1'b0; BUS_RD = 1'b0; BUS_WR = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
